// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-side initiator for the pipelined Booth/CSA multiplier.
// The unit accepts an M-extension multiply and converts signed operands to
// magnitudes. It launches the array with a one-cycle token and stalls EX until
// the array signals completion. It then sign-corrects the 2*DATA_WIDTH product,
// selects the low or high half and returns the result with a one-cycle strobe.
// Optional build macro: MUL_ZERO_BYPASS_EN. When this macro is defined, a
// request with a zero operand skips the array and completes with result 0.
module mul_issue_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int PIPE_LAT   = 5,
  parameter int TIMEOUT    = PIPE_LAT + 3
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      MulReq,
  input  logic [1:0]                MulOp,
  input  logic [DATA_WIDTH-1:0]     OpA,
  input  logic [DATA_WIDTH-1:0]     OpB,
  input  logic [4:0]                RdAddrIn,
  input  logic                      Flush,
  output logic [DATA_WIDTH-1:0]     MulA,
  output logic [DATA_WIDTH-1:0]     MulB,
  output logic [1:0]                MulHoldFlagToMul,
  input  logic                      MulHoldEndFromMul,
  input  logic [2*DATA_WIDTH-1:0]   SumFromMul,
  output logic                      MulStall,
  output logic                      MulResultValid,
  output logic [DATA_WIDTH-1:0]     MulResult,
  output logic [4:0]                MulRdAddr,
  output logic                      MulTimeoutErr
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [1:0]              op_q;
  logic                    neg_q;
  logic [4:0]              rd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   mul_a_q;
  logic [DATA_WIDTH-1:0]   mul_b_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [1:0]              flag_q;
  logic                    err_q;

  logic                    sign_a_d;
  logic                    sign_b_d;
  logic [DATA_WIDTH-1:0]   mul_a_d;
  logic [DATA_WIDTH-1:0]   mul_b_d;
  logic [PW-1:0]           prod_d;
  logic [DATA_WIDTH-1:0]   result_d;
  logic                    accept;
  logic                    cnt_expired;

`ifdef MUL_ZERO_BYPASS_EN
  logic                    zero_d;
  assign zero_d = (OpA == '0) || (OpB == '0);
`endif

  // Operand magnitudes for the array and sign correction of the array product.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    sign_a_d = 1'b0;
    sign_b_d = 1'b0;
    if (MulOp == 2'b01 || MulOp == 2'b10) sign_a_d = OpA[DATA_WIDTH-1];
    if (MulOp == 2'b01)                   sign_b_d = OpB[DATA_WIDTH-1];
    // Negating the most negative value wraps to 0x80..0, which is the correct magnitude.
    mul_a_d  = sign_a_d ? -OpA : OpA;
    mul_b_d  = sign_b_d ? -OpB : OpB;
    prod_d   = neg_q ? -SumFromMul : SumFromMul;
    result_d = (op_q == 2'b00) ? prod_d[DATA_WIDTH-1:0] : prod_d[PW-1:DATA_WIDTH];
  end

  assign accept      = MulReq && !Flush;
  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Issue FSM with registered operands, token, result and error flag.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous and active-low to match the array, which shares Rst.
    if (!Rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      flag_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      flag_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= MulOp;
            rd_q    <= RdAddrIn;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            neg_q   <= sign_a_d ^ sign_b_d;
`ifdef MUL_ZERO_BYPASS_EN
            if (zero_d) begin
              result_q <= '0;
              state_q  <= S_DONE;
            end else
`endif
            begin
              flag_q  <= 2'b01;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          cnt_q <= '0;
          if (Flush) begin
            flag_q  <= 2'b10;
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (MulHoldEndFromMul) begin
            result_q <= result_d;
            state_q  <= S_DONE;
          end else if (Flush) begin
            cnt_q   <= '0;
            flag_q  <= 2'b10;
            state_q <= S_DRAIN;
          end else if (cnt_expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // The cancelled product is discarded; only the end pulse matters.
          cnt_q <= cnt_q + CNT_W'(1);
          if (MulHoldEndFromMul) begin
            state_q <= S_IDLE;
          end else if (cnt_expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MulA             = mul_a_q;
  assign MulB             = mul_b_q;
  assign MulHoldFlagToMul = flag_q;
  assign MulResult        = result_q;
  assign MulRdAddr        = rd_q;
  assign MulTimeoutErr    = err_q;
  assign MulResultValid   = (state_q == S_DONE) && !Flush;
  assign MulStall         = ((state_q == S_IDLE) && accept) ||
                            (state_q == S_LAUNCH) || (state_q == S_BUSY);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: randomized and directed bench for mul_issue_ctrl.
// Expected results come from RISC-V MUL/MULH/MULHSU/MULHU arithmetic on
// sign- or zero-extended 128-bit values. A small array model returns the
// product after a configurable delay and counts launch and cancel tokens.
module tb_mul_issue_ctrl;

  localparam int DW       = 64;
  localparam int PIPE_LAT = 5;
  localparam int TIMEOUT  = PIPE_LAT + 3;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            Clk, Rst;
  logic            MulReq, Flush;
  logic [1:0]      MulOp;
  logic [DW-1:0]   OpA, OpB;
  logic [4:0]      RdAddrIn;
  logic [DW-1:0]   MulA, MulB;
  logic [1:0]      MulHoldFlagToMul;
  logic            MulHoldEndFromMul;
  logic [2*DW-1:0] SumFromMul;
  logic            MulStall, MulResultValid;
  logic [DW-1:0]   MulResult;
  logic [4:0]      MulRdAddr;
  logic            MulTimeoutErr;

  mul_issue_ctrl #(.DATA_WIDTH(DW), .PIPE_LAT(PIPE_LAT), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .MulReq(MulReq), .MulOp(MulOp), .OpA(OpA), .OpB(OpB),
    .RdAddrIn(RdAddrIn), .Flush(Flush), .MulA(MulA), .MulB(MulB),
    .MulHoldFlagToMul(MulHoldFlagToMul), .MulHoldEndFromMul(MulHoldEndFromMul),
    .SumFromMul(SumFromMul), .MulStall(MulStall), .MulResultValid(MulResultValid),
    .MulResult(MulResult), .MulRdAddr(MulRdAddr), .MulTimeoutErr(MulTimeoutErr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Array model controls and token counters.
  int arr_delay  = PIPE_LAT + 1;
  bit hold_low   = 1'b0;
  int launch_cnt = 0;
  int cancel_cnt = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] ref_mul(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic signed [2*DW-1:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    sb = (op == 2'b01) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  function automatic logic [DW-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(DW-1){1'b0}}};
      3:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Array model: latches the magnitudes when it sees the launch token. It
  // pulses the end signal arr_delay cycles later with the unsigned product.
  initial begin
    int cd;
    logic [2*DW-1:0] pend;
    cd = -1;
    pend = '0;
    MulHoldEndFromMul = 1'b0;
    SumFromMul = '0;
    forever begin
      @(posedge Clk);
      #1;
      MulHoldEndFromMul = 1'b0;
      if (!Rst) begin
        cd = -1;
      end else begin
        if (cd > 0) cd--;
        if (cd == 0) begin
          if (!hold_low) begin
            MulHoldEndFromMul = 1'b1;
            SumFromMul = pend;
          end
          cd = -1;
        end
        if (MulHoldFlagToMul[0]) begin
          launch_cnt++;
          pend = {{DW{1'b0}}, MulA} * {{DW{1'b0}}, MulB};
          cd = arr_delay;
        end
        if (MulHoldFlagToMul[1]) cancel_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  // Issue one request and watch it for up to max_cyc cycles.
  // flush_at is the cycle offset at which Flush pulses, or -1 for no flush.
  task automatic run_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [4:0] rd, input int flush_at, input int max_cyc,
                        output int lat, output int stall_n, output logic [DW-1:0] res,
                        output logic [4:0] rd_o, output logic [DW-1:0] ma,
                        output logic [DW-1:0] mb);
    lat = -1; stall_n = 0; res = '0; rd_o = '0; ma = '0; mb = '0;
    MulReq = 1'b1; MulOp = op; OpA = a; OpB = b; RdAddrIn = rd;
    for (int k = 0; k < max_cyc; k++) begin
      Flush = (k == flush_at);
      if (k > 0) MulReq = 1'b0;
      @(negedge Clk);
      if (MulStall) stall_n++;
      if (k == 1) begin ma = MulA; mb = MulB; end
      if (MulResultValid && lat < 0) begin lat = k; res = MulResult; rd_o = MulRdAddr; end
      step();
      if (lat >= 0) break;
    end
    MulReq = 1'b0;
    Flush  = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask

  initial begin
    int lat, stall_n, l0, c0, exp_lat;
    logic [DW-1:0] res, ma, mb, a, b;
    logic [4:0] rd_o, rd;
    logic [1:0] op;

    Rst = 1'b0; MulReq = 1'b0; Flush = 1'b0; MulOp = 2'b00;
    OpA = '0; OpB = '0; RdAddrIn = '0;
    step();
    step();
    @(negedge Clk);
    check("rst_state_mula", MulA, 0);
    check("rst_state_mulb", MulB, 0);
    check("rst_state_flag", MulHoldFlagToMul, 0);
    check("rst_state_result", MulResult, 0);
    check("rst_state_valid", MulResultValid, 0);
    check("rst_state_stall", MulStall, 0);
    check("rst_state_rd", MulRdAddr, 0);
    check("rst_state_err", MulTimeoutErr, 0);
    step();
    Rst = 1'b1;
    step();

    // MUL 3 x 5 at nominal latency.
    l0 = launch_cnt; c0 = cancel_cnt;
    run_op(2'b00, 64'd3, 64'd5, 5'd3, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("mul3x5_res", res, 15);
    check("mul3x5_lat", lat, PIPE_LAT + 3);
    check("mul3x5_stall", stall_n, PIPE_LAT + 3);
    check("mul3x5_launch", launch_cnt - l0, 1);
    check("mul3x5_cancel", cancel_cnt - c0, 0);
    check("mul3x5_rd", rd_o, 3);

    // Sign handling.
    run_op(2'b01, '1, '1, 5'd4, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("mulh_m1_ma", ma, 1);
    check("mulh_m1_mb", mb, 1);
    check("mulh_m1_res", res, 0);
    run_op(2'b11, '1, '1, 5'd5, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("mulhu_m1_ma", ma, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mulhu_m1_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(2'b10, -64'sd2, 64'd3, 5'd6, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("mulhsu_res", res, ref_mul(2'b10, -64'sd2, 64'd3));
    check("mulhsu_ma", ma, 2);
    run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, -1, 40,
           lat, stall_n, res, rd_o, ma, mb);
    check("mulh_min_res", res, 64'h4000_0000_0000_0000);

    // Flush two cycles after launch, then a normal MUL.
    l0 = launch_cnt; c0 = cancel_cnt;
    run_op(2'b00, 64'd9, 64'd9, 5'd8, 3, 20, lat, stall_n, res, rd_o, ma, mb);
    check("flush_busy_valid", lat, -1);
    check("flush_busy_cancel", cancel_cnt - c0, 1);
    check("flush_busy_launch", launch_cnt - l0, 1);
    check("flush_busy_stall", stall_n, 4);
    run_op(2'b00, 64'd7, 64'd6, 5'd9, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("post_flush_res", res, 42);
    check("post_flush_lat", lat, PIPE_LAT + 3);

    // Flush during LAUNCH: the token still goes out, followed by a cancel.
    l0 = launch_cnt; c0 = cancel_cnt;
    run_op(2'b00, 64'd2, 64'd2, 5'd1, 1, 20, lat, stall_n, res, rd_o, ma, mb);
    check("flush_launch_valid", lat, -1);
    check("flush_launch_tokens", {launch_cnt - l0, cancel_cnt - c0}, {32'd1, 32'd1});
    check("flush_launch_stall", stall_n, 2);

    // Flush in DONE suppresses the strobe.
    run_op(2'b00, 64'd2, 64'd2, 5'd1, PIPE_LAT + 3, 20, lat, stall_n, res, rd_o, ma, mb);
    check("flush_done_valid", lat, -1);
    check("flush_done_stall", stall_n, PIPE_LAT + 3);

    // Array never answers: timeout abort, sticky error, reset clears.
    hold_low = 1'b1;
    run_op(2'b00, 64'd2, 64'd3, 5'd2, -1, 20, lat, stall_n, res, rd_o, ma, mb);
    hold_low = 1'b0;
    check("timeout_valid", lat, -1);
    check("timeout_stall", stall_n, TIMEOUT + 2);
    @(negedge Clk);
    check("timeout_err", MulTimeoutErr, 1);
    check("timeout_stall_low", MulStall, 0);
    step();
    do_reset();
    @(negedge Clk);
    check("timeout_err_cleared", MulTimeoutErr, 0);
    step();

    // Zero operand: bypass or nominal path depending on the build.
    l0 = launch_cnt;
    run_op(2'b00, 64'd0, 64'd9, 5'd10, -1, 40, lat, stall_n, res, rd_o, ma, mb);
    check("zero_res", res, 0);
    check("zero_lat", lat, BYPASS ? 1 : PIPE_LAT + 3);
    check("zero_launch", launch_cnt - l0, BYPASS ? 0 : 1);
    check("zero_rd", rd_o, 10);

    // Randomized operations with random array delay up to the timeout boundary.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      arr_delay = $urandom_range(1, TIMEOUT);
      exp_lat = (BYPASS && (a == 0 || b == 0)) ? 1 : arr_delay + 2;
      run_op(op, a, b, rd, -1, 40, lat, stall_n, res, rd_o, ma, mb);
      check($sformatf("rand%0d_res op%0d", i, op), res, ref_mul(op, a, b));
      check($sformatf("rand%0d_lat", i), lat, exp_lat);
      check($sformatf("rand%0d_rd", i), rd_o, rd);
    end
    arr_delay = PIPE_LAT + 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
EX-side initiator for the pipelined Booth/CSA multiplier array. It accepts a RISC-V M-extension multiply from EX and converts signed operands to magnitudes. It then launches the operation into the array with the MulHoldFlag token, stalls EX, and waits for the array's MulHoldEnd. Finally it applies sign correction, selects the result half and returns the result to EX with a one-cycle valid.

Parameters:
DATA_WIDTH, 64, operand width; the array product is 2*DATA_WIDTH.
PIPE_LAT, 5, nominal cycles from launch token to MulHoldEndFromMul.
TIMEOUT, PIPE_LAT+3, BUSY cycles without an end before an error abort.

Ports:
Clk  in  1  clock
Rst  in  1  reset; synchronous, active-low
MulReq  in  1  EX multiply request; sampled only in IDLE
MulOp  in  2  00 MUL (low), 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
OpA  in  DATA_WIDTH  rs1 value
OpB  in  DATA_WIDTH  rs2 value
RdAddrIn  in  5  destination register
Flush  in  1  pipeline flush from control
MulA  out  DATA_WIDTH  multiplicand magnitude to array
MulB  out  DATA_WIDTH  multiplier magnitude to array
MulHoldFlagToMul  out  2  token to array: bit0 launch, bit1 cancel
MulHoldEndFromMul  in  1  array completion pulse
SumFromMul  in  2*DATA_WIDTH  unsigned product from final adder
MulStall  out  1  hold EX
MulResultValid  out  1  one-cycle result strobe
MulResult  out  DATA_WIDTH  result
MulRdAddr  out  5  destination for the result
MulTimeoutErr  out  1  sticky error, cleared only by reset

Behaviour:
- Reset (Rst==0 at posedge): state IDLE. All outputs 0, including MulA, MulB, flag, MulResult and MulTimeoutErr.
- FSM states: IDLE, LAUNCH, BUSY, DRAIN, DONE.
- IDLE:
  - MulReq=1 and Flush=0: latch MulOp and RdAddrIn.
  - signA = OpA[MSB] when MulOp is 01 or 10, else 0. signB = OpB[MSB] when MulOp is 01, else 0.
  - MulA = signA ? -OpA : OpA; MulB likewise. The two's-complement of the minimum value yields 0x8000..0 as an unsigned magnitude, which is correct.
  - Latch neg = signA^signB; go to LAUNCH.
  - MulStall is asserted combinationally in the request cycle.
- LAUNCH: MulHoldFlagToMul=2'b01 for exactly one cycle; MulA/MulB stay stable; clear the cycle counter; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - On MulHoldEndFromMul: P = neg ? -SumFromMul : SumFromMul (2*DATA_WIDTH-bit negate). Register MulResult = (MulOp==00) ? P[DATA_WIDTH-1:0] : P[2*DATA_WIDTH-1:DATA_WIDTH]. Go to DONE.
  - If Flush (without end): go to DRAIN.
  - If the counter reaches TIMEOUT: set MulTimeoutErr, go to IDLE, drop MulStall, no valid.
- DRAIN:
  - Drive MulHoldFlagToMul=2'b10 for one cycle.
  - Ignore SumFromMul and wait for MulHoldEndFromMul, which may arrive in the same cycle; the timeout applies here too.
  - Then go to IDLE with no valid. MulStall remains 0 during DRAIN; EX is already flushed.
  - A new MulReq is not accepted until IDLE.
- DONE: MulResultValid=1 and MulRdAddr valid for one cycle; MulStall=0; go to IDLE. A back-to-back MulReq is sampled in the following IDLE cycle.
- MulStall = 1 in IDLE (when the request is accepted), LAUNCH and BUSY.
- Flush in LAUNCH: the token is still issued, then go to DRAIN.
- Flush in DONE: suppress MulResultValid.
- MulHoldEndFromMul in IDLE or DONE: ignore it (spurious).
- Reset mid-operation returns to IDLE immediately. The array is reset by the same Rst, so no drain is needed.
- Nominal latency from request to MulResultValid is PIPE_LAT+3 cycles.

Optional Feature:
MUL_ZERO_BYPASS_EN.
- Defined: in IDLE, if MulReq and (OpA==0 or OpB==0), skip the array entirely. Go directly to DONE with MulResult=0: MulStall high 1 cycle, valid in the next cycle. No launch token is issued.
- Undefined: all requests go through the array; zero operands take the nominal latency.

Test Plan:
- MUL 3 x 5 -> after PIPE_LAT+3 cycles, MulResultValid=1, MulResult=15, MulStall high throughout until DONE, exactly one 2'b01 token.
- MULH 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> MulA=MulB=1, MulResult=0. MULHU with the same operands -> MulResult=0xFFFF_FFFF_FFFF_FFFE.
- MULHSU OpA=-2 x OpB=3 -> MulResult=0xFFFF_FFFF_FFFF_FFFF; MULH 0x8000..0 x 0x8000..0 -> 0x4000_0000_0000_0000.
- Flush 2 cycles after launch -> 2'b10 token issued, no MulResultValid, FSM IDLE after the end pulse, next MUL 7x6 returns 42.
- Model holds MulHoldEndFromMul low -> MulTimeoutErr=1 after TIMEOUT BUSY cycles, MulStall drops, no valid; Rst=0 clears the error.
- With MUL_ZERO_BYPASS_EN: MUL 0 x 9 -> MulResultValid in the cycle after the request, MulResult=0, no launch token observed.
